// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multi-cycle MIPS control FSM.
// Holds opcode/funct constants, ALU codes, mux select codes,
// the state encoding and the decoded instruction classes.
package mc_ctrl_pkg;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (instruction[5:0])
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SRA = 3'b100;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_SEXT = 2'd1;
    localparam logic [1:0] SRCB_ZEXT = 2'd2;
    localparam logic [1:0] SRCB_LUI  = 2'd3;

    // Register-file destination select
    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    // Register-file write-data select
    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;

    // Next-PC select
    localparam logic [1:0] NPC_PC4 = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_JMP = 2'd2;
    localparam logic [1:0] NPC_RS  = 2'd3;

    // Controller state encoding, exported on state_o for debug
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DCD      = 4'd1,
        ST_EXE_R    = 4'd2,
        ST_EXE_I    = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_ALU   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_BR       = 4'd9,
        ST_JMP      = 4'd10
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_RTYPE   = 4'd1,
        CLS_JR      = 4'd2,
        CLS_ORI     = 4'd3,
        CLS_LUI     = 4'd4,
        CLS_LW      = 4'd5,
        CLS_SW      = 4'd6,
        CLS_BEQ     = 4'd7,
        CLS_J       = 4'd8,
        CLS_JAL     = 4'd9
    } iclass_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: combinational instruction decoder.
// Maps op/funct to an instruction class and, for the ALU R-type
// instructions, the ALU operation taken straight from funct.
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output iclass_t    o_class,
    output logic [2:0] o_alu_r
);

    // Classify the instruction; anything unrecognised stays illegal
    always_comb begin
        o_class = CLS_ILLEGAL;
        o_alu_r = ALU_ADD;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: begin
                        o_class = CLS_RTYPE;
                        o_alu_r = ALU_ADD;
                    end
                    FN_SUBU: begin
                        o_class = CLS_RTYPE;
                        o_alu_r = ALU_SUB;
                    end
                    FN_AND: begin
                        o_class = CLS_RTYPE;
                        o_alu_r = ALU_AND;
                    end
                    FN_OR: begin
                        o_class = CLS_RTYPE;
                        o_alu_r = ALU_OR;
                    end
                    FN_SRAV: begin
                        o_class = CLS_RTYPE;
                        o_alu_r = ALU_SRA;
                    end
                    FN_JR: begin
                        o_class = CLS_JR;
                    end
                    default: begin
                        o_class = CLS_ILLEGAL;
                    end
                endcase
            end
            OP_ORI:  o_class = CLS_ORI;
            OP_LUI:  o_class = CLS_LUI;
            OP_LW:   o_class = CLS_LW;
            OP_SW:   o_class = CLS_SW;
            OP_BEQ:  o_class = CLS_BEQ;
            OP_J:    o_class = CLS_J;
            OP_JAL:  o_class = CLS_JAL;
            default: o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back and drives every
// datapath enable and mux select from the state and the held IR fields.
// Optional feature: define MC_CTRL_RETIRE_CNT_EN to add the 32-bit
// 'retired' instruction counter output.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        eq,
    input  logic        mem_ack,
    output logic        pc_wr,
    output logic        ir_wr,
    output logic        reg_wr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [2:0]  alu_ctr,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic [1:0]  npc_sel,
    output logic [3:0]  state_o
`ifdef MC_CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0] retired
`endif
);

    state_t     r_state;
    state_t     w_next;
    iclass_t    w_class;
    logic [2:0] w_alu_r;
    logic       w_ack;

    mc_ctrl_dec u_dec (
        .i_op    (op),
        .i_funct (funct),
        .o_class (w_class),
        .o_alu_r (w_alu_r)
    );

    // Without memory wait states every memory access completes in one cycle
    assign w_ack = (MEM_WAIT == 0) ? 1'b1 : mem_ack;

    assign state_o = r_state;

    // State register; reset aborts any instruction and returns to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state sequencing
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (w_ack) begin
                    w_next = ST_DCD;
                end
            end
            ST_DCD: begin
                case (w_class)
                    CLS_RTYPE:       w_next = ST_EXE_R;
                    CLS_JR:          w_next = ST_JMP;
                    CLS_ORI,
                    CLS_LUI:         w_next = ST_EXE_I;
                    CLS_LW,
                    CLS_SW:          w_next = ST_MEM_ADDR;
                    CLS_BEQ:         w_next = ST_BR;
                    CLS_J,
                    CLS_JAL:         w_next = ST_JMP;
                    default:         w_next = ST_FETCH;
                endcase
            end
            ST_EXE_R:    w_next = ST_WB_ALU;
            ST_EXE_I:    w_next = ST_WB_ALU;
            ST_MEM_ADDR: w_next = (w_class == CLS_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (w_ack) begin
                    w_next = ST_WB_MEM;
                end
            end
            ST_MEM_WR: begin
                if (w_ack) begin
                    w_next = ST_FETCH;
                end
            end
            ST_WB_ALU:   w_next = ST_FETCH;
            ST_WB_MEM:   w_next = ST_FETCH;
            ST_BR:       w_next = ST_FETCH;
            ST_JMP:      w_next = ST_FETCH;
            default:     w_next = ST_FETCH;
        endcase
    end

    // Output decode; everything is forced idle while reset is asserted
    always_comb begin
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        reg_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        alu_ctr   = ALU_ADD;
        alu_src_b = SRCB_RT;
        reg_dst   = DST_RT;
        wd_sel    = WD_ALU;
        npc_sel   = NPC_PC4;
        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    mem_rd = 1'b1;
                    if (w_ack) begin
                        ir_wr = 1'b1;
                        pc_wr = 1'b1;
                    end
                end
                ST_EXE_R: begin
                    alu_ctr = w_alu_r;
                end
                ST_EXE_I: begin
                    alu_ctr   = ALU_OR;
                    alu_src_b = (w_class == CLS_LUI) ? SRCB_LUI : SRCB_ZEXT;
                end
                ST_MEM_ADDR: begin
                    alu_ctr   = ALU_ADD;
                    alu_src_b = SRCB_SEXT;
                end
                ST_MEM_RD: begin
                    mem_rd = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_wr = 1'b1;
                end
                ST_WB_ALU: begin
                    reg_wr  = 1'b1;
                    reg_dst = (w_class == CLS_RTYPE) ? DST_RD : DST_RT;
                end
                ST_WB_MEM: begin
                    reg_wr = 1'b1;
                    wd_sel = WD_MEM;
                end
                ST_BR: begin
                    alu_ctr = ALU_SUB;
                    pc_wr   = eq;
                    npc_sel = NPC_BR;
                end
                ST_JMP: begin
                    pc_wr = 1'b1;
                    if (w_class == CLS_JR) begin
                        npc_sel = NPC_RS;
                    end else begin
                        npc_sel = NPC_JMP;
                    end
                    if (w_class == CLS_JAL) begin
                        reg_wr  = 1'b1;
                        reg_dst = DST_RA;
                        wd_sel  = WD_PC4;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MC_CTRL_RETIRE_CNT_EN
    logic [31:0] r_retired;

    // Count instructions that complete; the illegal-op exit from DCD is not a retirement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= 32'd0;
        end else if ((r_state != ST_FETCH) && (r_state != ST_DCD) && (w_next == ST_FETCH)) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`endif

endmodule
